key_challenge_master: RTL and testbench
=======================================

# key_challenge_master

Host-side initiator for the cartridge security key. Issues a programmable sequence of challenge read cycles into the key's select window and samples the key's one-bit response on each cycle. Assembles the responses into a signature and compares it against an expected value. Sits between the boot sequencer and the cartridge bus: it drives the key select and address lines, and reports pass/fail to the boot ROM controller.

## Interface
- SEQ_LEN, 16, number of challenge accesses per run (legal 1..32)
- SETTLE, 1, idle cycles between accesses (legal 0..7)
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin a run; honoured only in IDLE
- abort  in  1  terminate current run; honoured in any non-IDLE state
- expect_sig  in  SEQ_LEN  expected response signature; captured on accepted start
- nibble_in  in  4  challenge nibble for step step_idx; external table, combinational lookup
- step_idx  out  5  index of current challenge step
- sser_n  out  1  key select, active-low
- ba13  out  1  address bit 13
- ba12  out  1  address bit 12
- ba  out  4  address bits 7..4 (challenge nibble)
- br_w  out  1  read/write; 1 = read
- sdrd  in  1  key response bit; board pull-up, so undriven reads as 1
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run or abort
- pass  out  1  signature matched; valid from done until next accepted start
- resp  out  SEQ_LEN  captured response signature; resp[0] = first access

## Operation
- The key window is selected only when sser_n=0, ba13=0, ba12=1 and br_w=1. Outside STROBE the block drives sser_n=1, ba13=1, ba12=0, br_w=1 and ba=0, so the key never advances.
- FSM states are IDLE, SETUP, STROBE, GAP, CHECK.
- IDLE: on start=1 (and abort=0), capture expect_sig, clear resp, set step=0, go to SETUP.
- SETUP: drive ba=nibble_in, ba13=0, ba12=1, sser_n=1. Registered ba then holds stable through STROBE. Go to STROBE.
- STROBE: sser_n=0 for exactly one cycle. On the closing edge:
  - sample sdrd into resp[step], because the key's response is combinational from its pre-edge state;
  - the key advances its state on that same edge.
  - Then go to GAP if SETTLE>0. Otherwise go to SETUP (next step), or to CHECK if step==SEQ_LEN-1.
- GAP: SETTLE cycles with the window deselected, then go to SETUP (step+1) or to CHECK.
- CHECK: set pass = (resp == captured expect_sig), pulse done, go to IDLE.
- Abort in SETUP, STROBE or GAP:
  - next cycle is IDLE with sser_n=1;
  - done pulses and pass=0;
  - resp holds the partial samples, with unsampled bits 0.
  - A STROBE edge coinciding with abort still samples that bit.
- Abort and start together in IDLE: start is ignored.
- The key has no reset. Any synchronisation prefix is part of the nibble table, and the response bits from that prefix are included in expect_sig.
- step_idx reads 0 in IDLE and saturates at SEQ_LEN-1.

## Timing
- Reset values: sser_n=1, ba13=1, ba12=0, br_w=1, ba=0, busy=0, done=0, pass=0, resp=0, step_idx=0, state IDLE.
- Reset mid-run takes effect on the next edge. sser_n is deasserted immediately and no partial done is produced.
- busy=1 from the cycle after an accepted start through the CHECK cycle, inclusive.
- Cycles per step: 2+SETTLE. Start-to-done latency: SEQ_LEN*(2+SETTLE)+1 cycles; done is asserted in CHECK.
- The key sees at most one select edge per step. sser_n is never low on two consecutive cycles.
- start asserted while busy is ignored and not queued.
- nibble_in must be valid combinationally in the SETUP cycle for the current step_idx.

## Test plan
- SEQ_LEN=4, SETTLE=1, nibbles 5,9,B,1; key model returns 1,0,1,1 and expect_sig=4'b1101 -> done at cycle 13 after start, pass=1, resp=4'b1101, sser_n low exactly 4 cycles.
- Same stimulus, expect_sig=4'b1100 -> pass=0, resp=4'b1101.
- Key absent (sdrd floats to 1), SEQ_LEN=16 -> resp=16'hFFFF; pass=1 only if expect_sig=16'hFFFF.
- Abort asserted during the third STROBE -> next cycle IDLE, done=1, pass=0, resp=4'b0x??. The third bit is sampled and bit 3 is 0.
- start pulsed again mid-run -> ignored, latency unchanged. rst_n=0 mid-GAP -> next cycle all outputs at reset values, no done.
- SETTLE=0 -> sser_n alternates 1,0 per step, latency SEQ_LEN*2+1, and the address stays stable across each select cycle.

Source files
------------

// File: rtl/key_challenge_master.sv
// Host-side challenge initiator for the cartridge security key: walks a nibble table
// through the key select window, collects one response bit per access, and checks the signature.
//
// state  | meaning
// IDLE   | window deselected, waiting for start
// SETUP  | address (ba13=0, ba12=1, ba=nibble) presented, select still high
// STROBE | select low for one cycle, response sampled on the closing edge
// GAP    | SETTLE idle cycles with the window deselected
// CHECK  | compare signature, pulse done
module key_challenge_master #(
    parameter int SEQ_LEN = 16,
    parameter int SETTLE  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [SEQ_LEN-1:0] expect_sig,
    input  logic [3:0]         nibble_in,
    output logic [4:0]         step_idx,
    output logic               sser_n,
    output logic               ba13,
    output logic               ba12,
    output logic [3:0]         ba,
    output logic               br_w,
    input  logic               sdrd,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [SEQ_LEN-1:0] resp
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, GAP, CHECK} state_t;

    localparam logic [4:0] LAST_STEP = 5'(SEQ_LEN - 1);
    localparam logic [2:0] GAP_LOAD  = (SETTLE > 0) ? 3'(SETTLE - 1) : 3'd0;

    state_t             state_q, state_nxt;
    logic [4:0]         step_q, step_nxt;
    logic [2:0]         gap_q, gap_nxt;
    logic [3:0]         ba_q;
    logic [SEQ_LEN-1:0] exp_q, resp_q, resp_nxt;
    logic               pass_q, pass_nxt, done_q, done_nxt;
    logic               accept;

    assign accept = (state_q == IDLE) && start && !abort;

    always_comb begin
        state_nxt = state_q;
        step_nxt  = step_q;
        gap_nxt   = gap_q;
        resp_nxt  = resp_q;
        pass_nxt  = pass_q;
        done_nxt  = 1'b0;

        // The key output is combinational from its pre-edge state, so sample on the STROBE closing edge.
        if (state_q == STROBE) begin
            for (int i = 0; i < SEQ_LEN; i++) begin
                if (step_q == 5'(i)) resp_nxt[i] = sdrd;
            end
        end

        case (state_q)
            IDLE: begin
                step_nxt = 5'd0;
                if (accept) begin
                    state_nxt = SETUP;
                    resp_nxt  = '0;
                    pass_nxt  = 1'b0;
                end
            end
            SETUP: state_nxt = STROBE;
            STROBE: begin
                if (SETTLE > 0) begin
                    state_nxt = GAP;
                    gap_nxt   = GAP_LOAD;
                end else if (step_q == LAST_STEP) begin
                    state_nxt = CHECK;
                end else begin
                    state_nxt = SETUP;
                    step_nxt  = step_q + 5'd1;
                end
            end
            GAP: begin
                if (gap_q != 3'd0) begin
                    gap_nxt = gap_q - 3'd1;
                end else if (step_q == LAST_STEP) begin
                    state_nxt = CHECK;
                end else begin
                    state_nxt = SETUP;
                    step_nxt  = step_q + 5'd1;
                end
            end
            CHECK: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (state_nxt == CHECK) begin
            done_nxt = 1'b1;
            pass_nxt = (resp_nxt == exp_q);
        end

        if (abort && (state_q == SETUP || state_q == STROBE || state_q == GAP)) begin
            state_nxt = IDLE;
            step_nxt  = 5'd0;
            done_nxt  = 1'b1;
            pass_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= 5'd0;
            gap_q   <= 3'd0;
            ba_q    <= 4'd0;
            exp_q   <= '0;
            resp_q  <= '0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            step_q  <= step_nxt;
            gap_q   <= gap_nxt;
            resp_q  <= resp_nxt;
            pass_q  <= pass_nxt;
            done_q  <= done_nxt;
            if (accept) exp_q <= expect_sig;
            if (state_q == SETUP) ba_q <= nibble_in;
        end
    end

    always_comb begin
        sser_n   = (state_q != STROBE);
        ba13     = !(state_q == SETUP || state_q == STROBE);
        ba12     = (state_q == SETUP || state_q == STROBE);
        br_w     = 1'b1;
        ba       = 4'd0;
        if (state_q == SETUP)  ba = nibble_in;
        if (state_q == STROBE) ba = ba_q;
        step_idx = (state_q == IDLE) ? 5'd0 : step_q;
        busy     = (state_q != IDLE);
        done     = done_q;
        pass     = pass_q;
        resp     = resp_q;
    end

endmodule

// File: tb/tb_key_challenge_master.sv
// Directed bench for key_challenge_master: table of 4-step runs against a behavioural key,
// plus SETTLE=0, key-absent 16-step, reset-mid-run and start/abort corner sequences.
module tb_key_challenge_master;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic abort = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] nib_tab [0:3];
    logic [3:0] key_pat;
    initial begin
        nib_tab[0] = 4'h5; nib_tab[1] = 4'h9; nib_tab[2] = 4'hB; nib_tab[3] = 4'h1;
        key_pat = 4'b1101;
    end

    // DUT with SEQ_LEN=4, SETTLE=1
    logic start4 = 1'b0, key_clr4 = 1'b0;
    logic [3:0] exp4 = 4'd0, nib4, ba4, resp4;
    logic [4:0] step4;
    logic sser4, b13_4, b12_4, brw4, sdrd4, busy4, done4, pass4;
    logic [1:0] k4 = 2'd0;

    // DUT with SEQ_LEN=4, SETTLE=0
    logic start0 = 1'b0, key_clr0 = 1'b0;
    logic [3:0] exp0 = 4'd0, nib0, ba0, resp0;
    logic [4:0] step0;
    logic sser0, b13_0, b12_0, brw0, sdrd0, busy0, done0, pass0;
    logic [1:0] k0 = 2'd0;

    // DUT with SEQ_LEN=16, SETTLE=1, key absent
    logic start16 = 1'b0;
    logic [15:0] exp16 = 16'd0, resp16;
    logic [3:0] nib16, ba16;
    logic [4:0] step16;
    logic sser16, b13_16, b12_16, brw16, busy16, done16, pass16;
    logic sdrd16 = 1'b1;

    assign nib4  = nib_tab[step4[1:0]];
    assign nib0  = nib_tab[step0[1:0]];
    assign nib16 = nib_tab[step16[1:0]];
    assign sdrd4 = key_pat[k4];
    assign sdrd0 = key_pat[k0];

    key_challenge_master #(.SEQ_LEN(4), .SETTLE(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort), .expect_sig(exp4),
        .nibble_in(nib4), .step_idx(step4), .sser_n(sser4), .ba13(b13_4), .ba12(b12_4),
        .ba(ba4), .br_w(brw4), .sdrd(sdrd4), .busy(busy4), .done(done4), .pass(pass4), .resp(resp4));

    key_challenge_master #(.SEQ_LEN(4), .SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort), .expect_sig(exp0),
        .nibble_in(nib0), .step_idx(step0), .sser_n(sser0), .ba13(b13_0), .ba12(b12_0),
        .ba(ba0), .br_w(brw0), .sdrd(sdrd0), .busy(busy0), .done(done0), .pass(pass0), .resp(resp0));

    key_challenge_master #(.SEQ_LEN(16), .SETTLE(1)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .abort(abort), .expect_sig(exp16),
        .nibble_in(nib16), .step_idx(step16), .sser_n(sser16), .ba13(b13_16), .ba12(b12_16),
        .ba(ba16), .br_w(brw16), .sdrd(sdrd16), .busy(busy16), .done(done16), .pass(pass16), .resp(resp16));

    // Behavioural key: advances on every edge that closes a valid select window.
    always @(posedge clk) begin
        if (key_clr4) k4 <= 2'd0;
        else if (!sser4 && !b13_4 && b12_4 && brw4) k4 <= k4 + 2'd1;
        if (key_clr0) k0 <= 2'd0;
        else if (!sser0 && !b13_0 && b12_0 && brw0) k0 <= k0 + 2'd1;
    end

    int sel4 = 0, aerr4 = 0, sel0 = 0, aerr0 = 0;
    logic low4 = 1'b0, low0 = 1'b0;
    always @(negedge clk) begin
        if (!sser4) begin
            sel4++;
            if (ba4 !== nib_tab[step4[1:0]] || b13_4 !== 1'b0 || b12_4 !== 1'b1 || brw4 !== 1'b1 || low4) aerr4++;
        end
        if (!sser0) begin
            sel0++;
            if (ba0 !== nib_tab[step0[1:0]] || b13_0 !== 1'b0 || b12_0 !== 1'b1 || brw0 !== 1'b1 || low0) aerr0++;
        end
        low4 = !sser4;
        low0 = !sser0;
    end

    int n_total = 0, n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act !== want) $display("FAIL %s: got %0h, expected %0h", name, act, want);
        else n_pass++;
    endtask

    typedef struct {
        logic [3:0] exp_sig;
        int         abort_at;
        int         restart_at;
        logic [3:0] want_resp;
        logic       want_pass;
        int         want_lat;
        int         want_sel;
    } vec_t;

    vec_t vecs [0:6];

    task automatic run4(input vec_t v, input int idx);
        int lat = 0;
        logic b1 = 1'b0;
        @(negedge clk);
        key_clr4 = 1'b1;
        exp4 = v.exp_sig;
        @(negedge clk);
        key_clr4 = 1'b0;
        sel4 = 0;
        aerr4 = 0;
        start4 = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            start4 = (c == v.restart_at);
            abort = (c == v.abort_at);
            if (c == 1) b1 = busy4;
            if (done4) begin
                lat = c;
                break;
            end
        end
        start4 = 1'b0;
        abort = 1'b0;
        check($sformatf("v%0d latency", idx), lat, v.want_lat);
        check($sformatf("v%0d resp", idx), resp4, v.want_resp);
        check($sformatf("v%0d pass", idx), pass4, v.want_pass);
        check($sformatf("v%0d selects", idx), sel4, v.want_sel);
        check($sformatf("v%0d addr_window", idx), aerr4, 0);
        check($sformatf("v%0d busy_first", idx), b1, 1);
        @(negedge clk);
        check($sformatf("v%0d after_done", idx), {busy4, done4, pass4}, {2'b00, v.want_pass});
    endtask

    initial begin
        //           exp     abort restart resp     pass lat sel
        vecs[0] = '{4'b1101, 0,    0,      4'b1101, 1,   13, 4};
        vecs[1] = '{4'b1100, 0,    0,      4'b1101, 0,   13, 4};
        vecs[2] = '{4'b0010, 0,    0,      4'b1101, 0,   13, 4};
        vecs[3] = '{4'b1101, 8,    0,      4'b0101, 0,   9,  3};
        vecs[4] = '{4'b0101, 2,    0,      4'b0001, 0,   3,  1};
        vecs[5] = '{4'b1101, 1,    0,      4'b0000, 0,   2,  0};
        vecs[6] = '{4'b1101, 0,    5,      4'b1101, 1,   13, 4};

        repeat (3) @(negedge clk);
        check("reset ctl", {sser4, b13_4, b12_4, brw4, busy4, done4, pass4}, 7'b1101000);
        check("reset addr", {step4, ba4, resp4}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run4(vecs[i], i);

        // start together with abort in IDLE is ignored
        start4 = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        abort = 1'b0;
        check("start_abort busy", {busy4, done4}, 2'b00);

        // reset during the GAP of step 1
        begin
            int dn = 0;
            key_clr4 = 1'b1;
            @(negedge clk);
            key_clr4 = 1'b0;
            exp4 = 4'b1101;
            start4 = 1'b1;
            for (int c = 1; c <= 6; c++) begin
                @(negedge clk);
                start4 = 1'b0;
            end
            check("pre_reset state", {sser4, step4, resp4}, {1'b1, 5'd1, 4'b0001});
            rst_n = 1'b0;
            @(negedge clk);
            check("mid_reset ctl", {sser4, b13_4, b12_4, brw4, busy4, done4, pass4}, 7'b1101000);
            check("mid_reset addr", {step4, ba4, resp4}, 0);
            rst_n = 1'b1;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (done4 || busy4) dn++;
            end
            check("mid_reset no_done", dn, 0);
        end

        // SETTLE=0: select alternates every cycle
        begin
            int lat = 0, perr = 0;
            key_clr0 = 1'b1;
            exp0 = 4'b1101;
            @(negedge clk);
            key_clr0 = 1'b0;
            sel0 = 0;
            aerr0 = 0;
            start0 = 1'b1;
            for (int c = 1; c <= 50; c++) begin
                @(negedge clk);
                start0 = 1'b0;
                if (sser0 !== ((c % 2 == 0 && c <= 8) ? 1'b0 : 1'b1)) perr++;
                if (done0) begin
                    lat = c;
                    break;
                end
            end
            check("s0 latency", lat, 9);
            check("s0 resp_pass", {resp0, pass0}, {4'b1101, 1'b1});
            check("s0 selects", sel0, 4);
            check("s0 pattern", perr, 0);
            check("s0 addr_window", aerr0, 0);
        end

        // key absent, SEQ_LEN=16
        for (int r = 0; r < 2; r++) begin
            int lat = 0;
            exp16 = (r == 0) ? 16'hFFFF : 16'hFFFE;
            @(negedge clk);
            start16 = 1'b1;
            for (int c = 1; c <= 200; c++) begin
                @(negedge clk);
                start16 = 1'b0;
                if (done16) begin
                    lat = c;
                    break;
                end
            end
            check($sformatf("absent%0d latency", r), lat, 49);
            check($sformatf("absent%0d resp", r), resp16, 16'hFFFF);
            check($sformatf("absent%0d pass", r), pass16, (r == 0) ? 1 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
